pdm_delay_sum_beamformer: RTL



---
 rtl/pdm_bf_pkg.sv | 18 +
 rtl/pdm_delay_line.sv | 30 +++
 rtl/pdm_delay_sum_beamformer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pdm_bf_pkg.sv
// pdm_bf_pkg: shared types and width helpers for the PDM delay-and-sum beamformer.
package pdm_bf_pkg;

    typedef enum logic {FILL, RUN} fsm_state_t;

    function automatic int pc_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int dly_w(input int max_delay);
        return $clog2(max_delay);
    endfunction

    function automatic int out_w(input int n_mic, input int decim);
        return $clog2(n_mic * decim) + 2;
    endfunction

endpackage

// File: rtl/pdm_delay_line.sv
// pdm_delay_line: one channel's PDM shift register with a programmable tap.
// Delay 0 selects the live input bit; delay d selects the bit from d strobes ago.
module pdm_delay_line
    import pdm_bf_pkg::*;
#(
    parameter int MAX_DELAY = 32,
    parameter int DLY_W     = dly_w(MAX_DELAY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stb,
    input  logic             din,
    input  logic [DLY_W-1:0] delay,
    output logic             tap
);

    logic [MAX_DELAY-2:0] r_sr;
    logic [MAX_DELAY-1:0] w_line;

    assign w_line = {r_sr, din};
    assign tap    = w_line[delay];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sr <= '0;
        else if (stb)
            r_sr <= w_line[MAX_DELAY-2:0];
    end

endmodule

// File: rtl/pdm_delay_sum_beamformer.sv
// pdm_delay_sum_beamformer: per-channel delayed PDM bits summed as +-1 and boxcar-decimated.
// Optional CHAN_MASK_EN adds chan_en; masked channels contribute 0 instead of +-1.
module pdm_delay_sum_beamformer
    import pdm_bf_pkg::*;
#(
    parameter int N_MIC     = 16,
    parameter int MAX_DELAY = 32,
    parameter int DECIM     = 8,
    parameter int DLY_W     = dly_w(MAX_DELAY),
    parameter int OUT_W     = out_w(N_MIC, DECIM)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pdm_stb,
    input  logic [N_MIC-1:0]           pdm_data,
    input  logic                       cfg_we,
    input  logic [$clog2(N_MIC)-1:0]   cfg_ch,
    input  logic [DLY_W:0]             cfg_delay,
    output logic signed [OUT_W-1:0]    out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overrun,
    input  logic                       ovr_clr
`ifdef CHAN_MASK_EN
    ,
    input  logic [N_MIC-1:0]           chan_en
`endif
);

    localparam int PC_W  = pc_w(N_MIC);
    localparam int FRM_W = $clog2(DECIM);

    fsm_state_t               r_state, w_state_nx;
    logic [DLY_W-1:0]         r_fill, w_fill_nx;
    logic [FRM_W-1:0]         r_frm, w_frm_nx;
    logic signed [OUT_W-1:0]  r_acc, w_acc_nx, r_out, w_out_nx, w_term, w_sum;
    logic                     r_valid, w_valid_nx, r_ovr, w_ovr_nx;
    logic [DLY_W-1:0]         r_delay [N_MIC];
    logic [N_MIC-1:0]         w_taps, w_en;
    logic [PC_W-1:0]          w_pop, w_nen;
    logic [DLY_W-1:0]         w_sat;
    logic                     w_cfg, w_done, w_take;

`ifdef CHAN_MASK_EN
    assign w_en = chan_en;
`else
    assign w_en = '1;
`endif

    for (genvar c = 0; c < N_MIC; c++) begin : g_ch
        pdm_delay_line #(.MAX_DELAY(MAX_DELAY), .DLY_W(DLY_W)) u_dl (
            .clk   (clk),
            .rst   (rst),
            .stb   (pdm_stb),
            .din   (pdm_data[c]),
            .delay (r_delay[c]),
            .tap   (w_taps[c])
        );
    end

    always_comb begin
        w_pop = '0;
        w_nen = '0;
        for (int i = 0; i < N_MIC; i++) begin
            w_pop += PC_W'(w_taps[i] & w_en[i]);
            w_nen += PC_W'(w_en[i]);
        end
    end

    // Term is 2*active_ones - active_channels, i.e. the +-1 sum over enabled channels.
    assign w_term = OUT_W'({w_pop, 1'b0}) - OUT_W'(w_nen);
    assign w_sum  = r_acc + w_term;
    assign w_sat  = (cfg_delay > (DLY_W+1)'(MAX_DELAY - 1)) ? DLY_W'(MAX_DELAY - 1) : cfg_delay[DLY_W-1:0];
    assign w_cfg  = cfg_we && (32'(cfg_ch) < N_MIC);
    assign w_take = !r_valid || out_ready;

    always_comb begin
        w_state_nx = r_state;
        w_fill_nx  = r_fill;
        w_frm_nx   = r_frm;
        w_acc_nx   = r_acc;
        w_done     = 1'b0;
        if (w_cfg) begin
            w_state_nx = FILL;
            w_fill_nx  = DLY_W'(MAX_DELAY - 1);
            w_frm_nx   = '0;
            w_acc_nx   = '0;
        end else if (pdm_stb) begin
            if (r_state == FILL) begin
                w_fill_nx  = (r_fill == '0) ? r_fill : r_fill - 1'b1;
                w_state_nx = (r_fill == '0) ? RUN : FILL;
            end else begin
                w_done   = (r_frm == FRM_W'(DECIM - 1));
                w_frm_nx = r_frm + 1'b1;
                w_acc_nx = w_done ? '0 : w_sum;
            end
        end
        w_out_nx   = (w_done && w_take) ? w_sum : r_out;
        w_valid_nx = (w_done && w_take) || (r_valid && !out_ready);
        w_ovr_nx   = (r_ovr && !ovr_clr) || (w_done && !w_take);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
            r_fill  <= DLY_W'(MAX_DELAY - 1);
            r_frm   <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_fill  <= w_fill_nx;
            r_frm   <= w_frm_nx;
            r_acc   <= w_acc_nx;
            r_out   <= w_out_nx;
            r_valid <= w_valid_nx;
            r_ovr   <= w_ovr_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_MIC; i++)
                r_delay[i] <= '0;
        end else if (w_cfg) begin
            r_delay[cfg_ch] <= w_sat;
        end
    end

    assign out_data  = r_out;
    assign out_valid = r_valid;
    assign overrun   = r_ovr;

endmodule
